// File: rtl/iiitb_rv32i_pipe.sv
// iiitb_rv32i_pipe: 5-stage (IF/ID/EX/MEM/WB) in-order core for the reduced RV32 encoding.
// Loadable IMEM, EX-stage forwarding, load-use interlock, branch flush in EX, and HALT.
module iiitb_rv32i_pipe #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          RN,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [XLEN-1:0]               NPC,
    output logic [XLEN-1:0]               WB_OUT,
    output logic [4:0]                    WB_RD,
    output logic                          WB_VALID,
    output logic                          HALTED
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int SAW = $clog2(XLEN);

    localparam logic [6:0] OP_RR   = 7'd0;
    localparam logic [6:0] OP_RM   = 7'd1;
    localparam logic [6:0] OP_BR   = 7'd2;
    localparam logic [6:0] OP_SH   = 7'd3;
    localparam logic [6:0] OP_M    = 7'd4;
    localparam logic [6:0] OP_HALT = 7'd5;

    // The first seven codes line up with the RR f3 field so RR decode is a direct cast.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL
    } alu_op_t;

    typedef struct packed {
        logic           valid;
        logic [IAW-1:0] pc;
        logic [31:0]    ir;
    } ifid_t;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            mem_rd;
        logic            mem_wr;
        logic            br;
        logic            br_ne;
        logic            halt;
        logic            use_imm;
        alu_op_t         alu;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rsd;   // store-data source (rd field of SW)
        logic [IAW-1:0]  pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] d;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            mem_rd;
        logic            mem_wr;
        logic            halt;
        logic [4:0]      rd;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sdata;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            halt;
        logic [4:0]      rd;
        logic [XLEN-1:0] res;
    } memwb_t;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] rf   [NREG];

    logic [IAW-1:0] pc;
    logic           halt_seen;
    ifid_t          if_id;
    idex_t          id_ex;
    exmem_t         ex_mem;
    memwb_t         mem_wb;

    logic [2:0]      f3;
    idex_t           dec;
    logic            use_rs1, use_rs2, use_rsd;
    logic [XLEN-1:0] ex_a, ex_b, ex_d, ex_opb, ex_res;
    logic            ex_taken;
    logic [IAW-1:0]  ex_target;
    logic            load_use, fetch_stop;
    logic [XLEN-1:0] mem_rdata;

    assign NPC = XLEN'(pc);
    assign f3  = if_id.ir[14:12];

    // Register read in ID; a write retiring this same cycle is returned instead of the old value.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (mem_wb.valid && mem_wb.wen && mem_wb.rd == idx) return mem_wb.res;
        return rf[idx];
    endfunction

    // EX operand bypass: the younger result (EX/MEM) wins over MEM/WB; x0 is never bypassed.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] idx, input logic [XLEN-1:0] val);
        if (idx != 5'd0 && ex_mem.valid && ex_mem.wen && ex_mem.rd == idx) return ex_mem.res;
        if (idx != 5'd0 && mem_wb.valid && mem_wb.wen && mem_wb.rd == idx) return mem_wb.res;
        return val;
    endfunction

    // NOTE: IMEM and DMEM have no reset; program and data survive RN, and a same-cycle
    // write to the address being fetched is seen by the fetch only on the following cycle.
    // IMEM load port, usable in any cycle.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    // Decode the ID instruction; unknown op/f3 leaves every control bit clear (NOP).
    always_comb begin
        // NOTE: every output gets a default first so this block never infers a latch.
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rsd = 1'b0;
        dec.rd  = if_id.ir[11:7];
        dec.rsd = if_id.ir[11:7];
        dec.rs1 = if_id.ir[19:15];
        dec.rs2 = if_id.ir[24:20];
        dec.imm = {{(XLEN-12){if_id.ir[31]}}, if_id.ir[31:20]};
        dec.pc  = if_id.pc;
        if (if_id.valid) begin
            dec.valid = 1'b1;
            case (if_id.ir[6:0])
                OP_RR: if (f3 != 3'd7) begin
                    dec.wen = 1'b1; dec.alu = alu_op_t'({1'b0, f3});
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_RM: if (f3 == 3'd0) begin
                    dec.wen = 1'b1; dec.use_imm = 1'b1; use_rs1 = 1'b1;
                end
                OP_SH: if (f3 <= 3'd1) begin
                    dec.wen = 1'b1; dec.alu = f3[0] ? ALU_SRL : ALU_SLL;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_M: if (f3 == 3'd0) begin
                    dec.wen = 1'b1; dec.mem_rd = 1'b1; dec.use_imm = 1'b1; use_rs1 = 1'b1;
                end else if (f3 == 3'd1) begin
                    dec.mem_wr = 1'b1; dec.use_imm = 1'b1; use_rs1 = 1'b1; use_rsd = 1'b1;
                end
                OP_BR: if (f3 <= 3'd1) begin
                    dec.br = 1'b1; dec.br_ne = f3[0]; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_HALT: dec.halt = 1'b1;
                default: ;
            endcase
            dec.wen = dec.wen && (dec.rd != 5'd0);
        end
        dec.a = rf_read(dec.rs1);
        dec.b = rf_read(dec.rs2);
        dec.d = rf_read(dec.rsd);
    end

    // EX stage: bypassed operands, ALU and branch resolution.
    always_comb begin
        ex_a   = fwd(id_ex.rs1, id_ex.a);
        ex_b   = fwd(id_ex.rs2, id_ex.b);
        ex_d   = fwd(id_ex.rsd, id_ex.d);
        ex_opb = id_ex.use_imm ? id_ex.imm : ex_b;
        case (id_ex.alu)
            ALU_ADD:  ex_res = ex_a + ex_opb;
            ALU_SUB:  ex_res = ex_a - ex_opb;
            ALU_AND:  ex_res = ex_a & ex_opb;
            ALU_OR:   ex_res = ex_a | ex_opb;
            ALU_XOR:  ex_res = ex_a ^ ex_opb;
            ALU_SLT:  ex_res = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_opb)};
            ALU_SLTU: ex_res = {{(XLEN-1){1'b0}}, ex_a < ex_opb};
            ALU_SLL:  ex_res = ex_a << ex_opb[SAW-1:0];
            ALU_SRL:  ex_res = ex_a >> ex_opb[SAW-1:0];
            default:  ex_res = '0;
        endcase
        ex_taken  = id_ex.valid && id_ex.br && ((ex_a == ex_b) != id_ex.br_ne);
        ex_target = id_ex.pc + IAW'(1) + id_ex.imm[IAW-1:0];
    end

    // Hazards: a taken branch overrides the load-use interlock and squashes a younger HALT.
    always_comb begin
        load_use = id_ex.valid && id_ex.mem_rd && id_ex.wen && !ex_taken &&
                   ((use_rs1 && dec.rs1 == id_ex.rd) ||
                    (use_rs2 && dec.rs2 == id_ex.rd) ||
                    (use_rsd && dec.rsd == id_ex.rd));
        fetch_stop = halt_seen || (dec.halt && !ex_taken);
    end

    // Fetch: PC update and IF/ID capture (redirect, hold on load-use, stop after HALT).
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
        if (RN) begin
            pc        <= '0;
            if_id     <= '0;
            halt_seen <= 1'b0;
        end else if (ex_taken) begin
            pc    <= ex_target;
            if_id <= '0;
        end else if (load_use) begin
            pc    <= pc;
            if_id <= if_id;
        end else if (fetch_stop) begin
            if_id     <= '0;
            halt_seen <= 1'b1;
        end else begin
            pc    <= pc + IAW'(1);
            if_id <= '{valid: 1'b1, pc: pc, ir: imem[pc]};
        end
    end

    // ID/EX register; bubble on reset, branch squash or load-use interlock.
    always_ff @(posedge clk) begin
        if (RN || ex_taken || load_use) id_ex <= '0;
        else                           id_ex <= dec;
    end

    // EX/MEM register.
    always_ff @(posedge clk) begin
        if (RN) ex_mem <= '0;
        else    ex_mem <= '{valid: id_ex.valid, wen: id_ex.wen, mem_rd: id_ex.mem_rd,
                            mem_wr: id_ex.mem_wr, halt: id_ex.halt, rd: id_ex.rd,
                            res: ex_res, sdata: ex_d};
    end

    assign mem_rdata = dmem[DAW'(ex_mem.res)];

    // Data memory store in MEM; a store caught by reset is discarded.
    always_ff @(posedge clk) begin
        if (!RN && ex_mem.valid && ex_mem.mem_wr) dmem[DAW'(ex_mem.res)] <= ex_mem.sdata;
    end

    // MEM/WB register; loads take memory data, everything else the ALU result.
    always_ff @(posedge clk) begin
        if (RN) mem_wb <= '0;
        else    mem_wb <= '{valid: ex_mem.valid, wen: ex_mem.wen, halt: ex_mem.halt,
                            rd: ex_mem.rd, res: ex_mem.mem_rd ? mem_rdata : ex_mem.res};
    end

    // Writeback: register file, observation outputs and the sticky HALTED flag.
    always_ff @(posedge clk) begin
        if (RN) begin
            // NOTE: the register file is reset on purpose (REG[i] = i), unlike IMEM/DMEM.
            for (int i = 0; i < NREG; i++) rf[i] <= XLEN'(i);
            WB_OUT   <= '0;
            WB_RD    <= '0;
            WB_VALID <= 1'b0;
            HALTED   <= 1'b0;
        end else begin
            WB_VALID <= mem_wb.valid && mem_wb.wen;
            if (mem_wb.valid && mem_wb.wen) begin
                rf[mem_wb.rd] <= mem_wb.res;
                WB_OUT        <= mem_wb.res;
                WB_RD         <= mem_wb.rd;
            end
            if (mem_wb.valid && mem_wb.halt) HALTED <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iiitb_rv32i_pipe.sv
// Directed bench for iiitb_rv32i_pipe: each program is loaded under reset, run to HALT,
// and its writeback log (edge, rd, value) is compared with hand-computed expectations.
// Edge 0 is the first rising edge with RN low; an instruction fetched at edge k writes back at k+4.
module tb_iiitb_rv32i_pipe;
    localparam logic [31:0] HALT = 32'h0000_0005;
    localparam logic [31:0] NOP  = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        RN = 1'b1;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] NPC, WB_OUT;
    logic [4:0]  WB_RD;
    logic        WB_VALID, HALTED;

    int checks = 0;
    int errors = 0;
    int edge_no = -1;

    typedef struct {
        int          e;
        logic [4:0]  rd;
        logic [31:0] v;
    } wb_t;
    wb_t log_q[$];

    iiitb_rv32i_pipe dut (
        .clk(clk), .RN(RN), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .NPC(NPC), .WB_OUT(WB_OUT), .WB_RD(WB_RD),
        .WB_VALID(WB_VALID), .HALTED(HALTED)
    );

    always #5 clk = ~clk;

    // Edge counter relative to reset release.
    always @(posedge clk) edge_no <= RN ? -1 : edge_no + 1;

    // Writeback log, sampled away from the active edge.
    always @(negedge clk) if (!RN && WB_VALID) log_q.push_back('{edge_no, WB_RD, WB_OUT});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        RN = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(int a, logic [31:0] w);
        imem_waddr = 5'(a);
        imem_wdata = w;
        imem_we    = 1'b1;
        @(negedge clk);
        imem_we    = 1'b0;
    endtask

    task automatic release_reset(string tag);
        check({tag, ":rst_npc"},      NPC,      32'd0);
        check({tag, ":rst_wb_out"},   WB_OUT,   32'd0);
        check({tag, ":rst_wb_rd"},    WB_RD,    32'd0);
        check({tag, ":rst_wb_valid"}, WB_VALID, 32'd0);
        check({tag, ":rst_halted"},   HALTED,   32'd0);
        log_q.delete();
        RN = 1'b0;
    endtask

    // Returns at the falling edge that follows rising edge k.
    task automatic wait_edge(int k);
        for (int n = 0; n < 200 && edge_no < k; n++) @(negedge clk);
    endtask

    task automatic run_until_halt(string tag, int exp_edge, int exp_npc);
        int halt_edge = -1;
        for (int n = 0; n < 200 && halt_edge < 0; n++) begin
            @(negedge clk);
            if (HALTED) halt_edge = edge_no;
        end
        check({tag, ":halt_edge"}, halt_edge, exp_edge);
        repeat (4) @(negedge clk);
        check({tag, ":npc_frozen"}, NPC, exp_npc);
        check({tag, ":halted_holds"}, HALTED, 32'd1);
    endtask

    task automatic expect_wb(string tag, int idx, int e, int rd, logic [31:0] v);
        wb_t ent = '{-1, 'x, 'x};
        if (idx < log_q.size()) ent = log_q[idx];
        check($sformatf("%s:wb%0d_edge", tag, idx), ent.e, e);
        check($sformatf("%s:wb%0d_rd", tag, idx), ent.rd, rd);
        check($sformatf("%s:wb%0d_val", tag, idx), ent.v, v);
    endtask

    initial begin
        // 1: add r6,r1,r2 -> 3 at edge 4
        hold_reset();
        load(0, 32'h0020_8300);
        load(1, HALT);
        release_reset("t1");
        run_until_halt("t1", 5, 2);
        check("t1:wb_count", log_q.size(), 1);
        expect_wb("t1", 0, 4, 6, 32'd3);

        // 2: back-to-back dependency via EX/MEM bypass, no stall
        hold_reset();
        load(0, 32'h0020_8300);         // add r6,r1,r2
        load(1, 32'h0063_0380);         // add r7,r6,r6
        load(2, HALT);
        release_reset("t2");
        run_until_halt("t2", 6, 3);
        check("t2:wb_count", log_q.size(), 2);
        expect_wb("t2", 0, 4, 6, 32'd3);
        expect_wb("t2", 1, 5, 7, 32'd6);

        // 3: store, load, load-use with exactly one bubble
        hold_reset();
        load(0, 32'h0020_9184);         // sw r3, 2(r1)  -> DM[3] = 3
        load(1, 32'h0020_8684);         // lw r13, 2(r1)
        load(2, 32'h00D6_8700);         // add r14,r13,r13
        load(3, HALT);
        release_reset("t3");
        run_until_halt("t3", 8, 4);
        check("t3:wb_count", log_q.size(), 2);
        expect_wb("t3", 0, 5, 13, 32'd3);
        expect_wb("t3", 1, 7, 14, 32'd6);

        // 4: taken branch; the rs2 field overlaps imm, so r15 is zeroed first to make it r0==r15
        hold_reset();
        load(0, 32'h0000_0780);         // add r15,r0,r0
        for (int a = 1; a < 9; a++) load(a, NOP);
        load(9, 32'h00F0_0002);         // beq r0,r15,+15 -> 25
        load(10, 32'h0020_8300);        // squashed
        load(11, 32'h0063_0380);        // squashed
        load(12, HALT);
        load(25, 32'h0641_0A01);        // addi r20,r2,100
        load(26, HALT);
        release_reset("t4");
        wait_edge(11);
        check("t4:npc_target", NPC, 32'd25);
        run_until_halt("t4", 17, 27);
        check("t4:wb_count", log_q.size(), 2);
        expect_wb("t4", 0, 4, 15, 32'd0);
        expect_wb("t4", 1, 16, 20, 32'd102);

        // 5: bne not taken, signed vs unsigned compare, write to x0 dropped
        hold_reset();
        load(0, 32'hFFF0_0081);         // addi r1,r0,-1
        load(1, 32'h0010_9002);         // bne r1,r1,+1 (not taken)
        load(2, 32'h0020_D400);         // slt  r8,r1,r2
        load(3, 32'h0020_E480);         // sltu r9,r1,r2
        load(4, 32'h0020_8000);         // add r0,r1,r2
        load(5, HALT);
        release_reset("t5");
        run_until_halt("t5", 9, 6);
        check("t5:wb_count", log_q.size(), 3);
        expect_wb("t5", 0, 4, 1, 32'hFFFF_FFFF);
        expect_wb("t5", 1, 6, 8, 32'd1);
        expect_wb("t5", 2, 7, 9, 32'd0);
        check("t5:wb_rd_holds", WB_RD, 32'd9);
        check("t5:wb_out_holds", WB_OUT, 32'd0);

        // 6: HALT at 3 freezes fetch; RN pulse clears HALTED and the program reruns
        hold_reset();
        load(0, 32'h0020_8300);         // add r6,r1,r2
        load(1, 32'h0063_0380);         // add r7,r6,r6
        load(2, 32'h0641_0A01);         // addi r20,r2,100
        load(3, HALT);
        load(4, 32'h0020_8500);         // add r10,r1,r2 (never executes)
        release_reset("t6");
        wait_edge(4);
        check("t6:npc_freeze_early", NPC, 32'd4);
        wait_edge(6);
        check("t6:halted_before_wb", HALTED, 32'd0);
        run_until_halt("t6", 7, 4);
        check("t6:wb_count", log_q.size(), 3);
        expect_wb("t6", 0, 4, 6, 32'd3);
        expect_wb("t6", 1, 5, 7, 32'd6);
        expect_wb("t6", 2, 6, 20, 32'd102);
        hold_reset();
        release_reset("t6r");
        wait_edge(4);
        check("t6r:wb_valid", WB_VALID, 32'd1);
        check("t6r:wb_rd", WB_RD, 32'd6);
        check("t6r:wb_out", WB_OUT, 32'd3);
        run_until_halt("t6r", 7, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
